// File: rtl/scaler_pkg.sv
// Shared types and default raster for the scaler front-end.
// ctrl_state_t : frame-lock FSM states
// frame_err_t  : per-frame error flags as reported on o_err
// DEF_*        : default raster timing; HTOT/VTOT are the default totals
package scaler_pkg;

  typedef enum logic [1:0] {
    ST_UNLOCK,
    ST_SEARCH,
    ST_LOCKED
  } ctrl_state_t;

  typedef struct packed {
    logic vtot_err;
    logic vact_err;
    logic line_err;
  } frame_err_t;

  localparam int unsigned DEF_HSW  = 1;
  localparam int unsigned DEF_HBP  = 2;
  localparam int unsigned DEF_HACT = 10;
  localparam int unsigned DEF_HFP  = 2;
  localparam int unsigned DEF_VSW  = 1;
  localparam int unsigned DEF_VBP  = 1;
  localparam int unsigned DEF_VACT = 4;
  localparam int unsigned DEF_VFP  = 1;

  localparam int unsigned HTOT = DEF_HSW + DEF_HBP + DEF_HACT + DEF_HFP;
  localparam int unsigned VTOT = DEF_VSW + DEF_VBP + DEF_VACT + DEF_VFP;

  // Width of the good/bad frame counters of the lock FSM
  localparam int unsigned CNT_W = 8;

endpackage

// File: rtl/scaler_sync_edge.sv
// Sync input stage: polarity normalisation, one register, rising-edge pulse.
// clk, rst    : pixel clock, asynchronous active-high reset
// i_sync      : raw sync input, active level set by POL
// o_lvl       : registered sync, active high
// o_rise_c    : combinational pulse on the first cycle o_lvl is high
module scaler_sync_edge #(
  parameter bit POL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sync,
  output logic o_lvl,
  output logic o_rise_c
);

  logic lvl_d;

  // Normalised level and its one-cycle history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_lvl <= 1'b0;
      lvl_d <= 1'b0;
    end else begin
      o_lvl <= i_sync ^ POL;
      lvl_d <= o_lvl;
    end
  end

  assign o_rise_c = o_lvl & ~lvl_d;

endmodule

// File: rtl/scaler_timing_ctrl.sv
// Front-end timing controller for the scaler: measures vsync/hsync/de against
// the configured raster, locks through a frame-level FSM and emits delay-matched
// sync, pixel coordinates and strobes. o_scl_en gates the datapath to verified frames.
// Inputs : clk, rst (async, active high), i_vsync, i_hsync, i_de
// Outputs: o_vsync/o_hsync/o_de (2-clk delayed, active high), o_x/o_y (aligned to o_de),
//          o_frame_start, o_line_start, o_locked, o_scl_en, o_err {vtot, vact, line}
module scaler_timing_ctrl
  import scaler_pkg::*;
#(
  parameter bit          VSYNC_POL     = 1'b0,
  parameter bit          HSYNC_POL     = 1'b0,
  parameter int unsigned VSW           = DEF_VSW,
  parameter int unsigned VBP           = DEF_VBP,
  parameter int unsigned VACT          = DEF_VACT,
  parameter int unsigned VFP           = DEF_VFP,
  parameter int unsigned HSW           = DEF_HSW,
  parameter int unsigned HBP           = DEF_HBP,
  parameter int unsigned HACT          = DEF_HACT,
  parameter int unsigned HFP           = DEF_HFP,
  parameter int unsigned LOCK_FRAMES   = 2,
  parameter int unsigned UNLOCK_FRAMES = 2,
  parameter int unsigned XW            = 12,
  parameter int unsigned YW            = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_vsync,
  input  logic          i_hsync,
  input  logic          i_de,
  output logic          o_vsync,
  output logic          o_hsync,
  output logic          o_de,
  output logic [XW-1:0] o_x,
  output logic [YW-1:0] o_y,
  output logic          o_frame_start,
  output logic          o_line_start,
  output logic          o_locked,
  output logic          o_scl_en,
  output logic [2:0]    o_err
);

  localparam int unsigned H_TOT = HSW + HBP + HACT + HFP;
  localparam int unsigned V_TOT = VSW + VBP + VACT + VFP;

  function automatic logic [XW-1:0] sat_inc_x(input logic [XW-1:0] v);
    return (&v) ? v : v + XW'(1);
  endfunction

  function automatic logic [YW-1:0] sat_inc_y(input logic [YW-1:0] v);
    return (&v) ? v : v + YW'(1);
  endfunction

  logic            vs_lvl, vs_rise, hs_lvl, hs_rise, de_r;
  logic            hs_seen, line_err;
  logic [XW-1:0]   hcnt, x_cnt, x_cur;
  logic [YW-1:0]   line_cnt, vact_cnt, vact_close, y_cur;
  logic [XW:0]     hcnt_p1;
  logic            line_close, line_bad, line_err_close, frame_good;
  frame_err_t      frame_err;
  ctrl_state_t     state, state_nxt;
  logic [CNT_W-1:0] good_cnt, good_nxt, bad_cnt, bad_nxt;

  scaler_sync_edge #(.POL(VSYNC_POL)) u_vs_edge (
    .clk      (clk),
    .rst      (rst),
    .i_sync   (i_vsync),
    .o_lvl    (vs_lvl),
    .o_rise_c (vs_rise)
  );

  scaler_sync_edge #(.POL(HSYNC_POL)) u_hs_edge (
    .clk      (clk),
    .rst      (rst),
    .i_sync   (i_hsync),
    .o_lvl    (hs_lvl),
    .o_rise_c (hs_rise)
  );

  // Line-close check and frame error evaluation. A simultaneous vs edge sees the
  // line closed on this same cycle, so the ending frame owns its last line.
  always_comb begin
    hcnt_p1        = {1'b0, hcnt} + (XW+1)'(1);
    line_close     = hs_rise & hs_seen;
    line_bad       = line_close &
                     ((hcnt_p1 != (XW+1)'(H_TOT)) |
                      ((x_cnt != '0) & (x_cnt != XW'(HACT))));
    line_err_close = line_err | line_bad;
    vact_close     = (line_close && (x_cnt != '0)) ? sat_inc_y(vact_cnt) : vact_cnt;
    frame_err.vtot_err = (line_cnt != YW'(V_TOT));
    frame_err.vact_err = (vact_close != YW'(VACT));
    frame_err.line_err = line_err_close;
    frame_good     = ~|frame_err;
    x_cur          = hs_rise ? '0 : x_cnt;
    y_cur          = vs_rise ? '0 : vact_close;
  end

  // Raster counters; x_cnt doubles as the de count of the current line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_r     <= 1'b0;
      hs_seen  <= 1'b0;
      hcnt     <= '0;
      x_cnt    <= '0;
      line_cnt <= '0;
      vact_cnt <= '0;
      line_err <= 1'b0;
    end else begin
      de_r    <= i_de;
      hs_seen <= hs_seen | hs_rise;
      hcnt    <= hs_rise ? '0 : sat_inc_x(hcnt);
      x_cnt   <= de_r ? sat_inc_x(x_cur) : x_cur;
      if (vs_rise) begin
        line_cnt <= hs_rise ? YW'(1) : '0;
        vact_cnt <= '0;
        line_err <= 1'b0;
      end else begin
        line_cnt <= hs_rise ? sat_inc_y(line_cnt) : line_cnt;
        vact_cnt <= vact_close;
        line_err <= line_err_close;
      end
    end
  end

  // Lock FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_UNLOCK;
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_nxt;
      bad_cnt  <= bad_nxt;
    end
  end

  // Lock FSM next state; only a vs edge moves it, so lock changes on frame boundaries
  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    bad_nxt   = bad_cnt;
    if (vs_rise) begin
      unique case (state)
        ST_UNLOCK: begin
          state_nxt = ST_SEARCH;
          good_nxt  = '0;
        end
        ST_SEARCH: begin
          if (frame_good) begin
            good_nxt = good_cnt + CNT_W'(1);
            if (good_nxt >= CNT_W'(LOCK_FRAMES)) begin
              state_nxt = ST_LOCKED;
              bad_nxt   = '0;
            end
          end else begin
            good_nxt = '0;
          end
        end
        ST_LOCKED: begin
          if (!frame_good) begin
            bad_nxt = bad_cnt + CNT_W'(1);
            if (bad_nxt >= CNT_W'(UNLOCK_FRAMES)) begin
              state_nxt = ST_SEARCH;
              good_nxt  = '0;
            end
          end else begin
            bad_nxt = '0;
          end
        end
        default: state_nxt = ST_UNLOCK;
      endcase
    end
  end

  // Output stage: second register gives 2-clk latency on every output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_vsync       <= 1'b0;
      o_hsync       <= 1'b0;
      o_de          <= 1'b0;
      o_x           <= '0;
      o_y           <= '0;
      o_frame_start <= 1'b0;
      o_line_start  <= 1'b0;
      o_locked      <= 1'b0;
      o_scl_en      <= 1'b0;
      o_err         <= '0;
    end else begin
      o_vsync       <= vs_lvl;
      o_hsync       <= hs_lvl;
      o_de          <= de_r;
      o_x           <= de_r ? x_cur : '0;
      o_y           <= de_r ? y_cur : '0;
      o_frame_start <= vs_rise;
      o_line_start  <= de_r & (x_cur == '0);
      o_locked      <= (state_nxt == ST_LOCKED);
      o_scl_en      <= (state_nxt == ST_LOCKED);
      // The partial frame seen while unlocked is not reported
      if (vs_rise && (state != ST_UNLOCK)) begin
        o_err <= frame_err;
      end
    end
  end

endmodule

// File: tb/tb_scaler_timing_ctrl.sv
// Bench for scaler_timing_ctrl: a frame table drives raster stimulus into an
// active-high and an active-low (inverted stimulus) instance; every cycle both
// are compared with expectations built from the stimulus indices, delayed 2 clk.
module tb_scaler_timing_ctrl;
  import scaler_pkg::*;

  localparam int XW = 12;
  localparam int YW = 12;
  localparam int T_HSW  = DEF_HSW;
  localparam int T_HBP  = DEF_HBP;
  localparam int T_HACT = DEF_HACT;
  localparam int T_VSW  = DEF_VSW;
  localparam int T_VBP  = DEF_VBP;
  localparam int T_VACT = DEF_VACT;
  localparam int T_HTOT = HTOT;

  typedef struct {
    logic          vs, hs, de, fs, ls;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          lock;
    logic [2:0]    err;
    logic          vld;
  } exp_t;

  typedef struct {
    int         vfp;
    int         bad_hact;
    int         rst_line;
    logic [2:0] err;
    logic       lock;
  } frame_vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vs = 1'b0, hs = 1'b0, de = 1'b0;
  logic vs_n, hs_n;
  assign vs_n = ~vs;
  assign hs_n = ~hs;

  logic          p_vsync, p_hsync, p_de, p_fs, p_ls, p_lock, p_en;
  logic [XW-1:0] p_x;
  logic [YW-1:0] p_y;
  logic [2:0]    p_err;
  logic          n_vsync, n_hsync, n_de, n_fs, n_ls, n_lock, n_en;
  logic [XW-1:0] n_x;
  logic [YW-1:0] n_y;
  logic [2:0]    n_err;

  int   n_checks = 0;
  int   n_errors = 0;
  logic chk_en = 1'b1;
  exp_t pipe0, pipe1;
  frame_vec_t fv[16];

  always #5 clk = ~clk;

  scaler_timing_ctrl #(.VSYNC_POL(1'b0), .HSYNC_POL(1'b0)) dut_p (
    .clk(clk), .rst(rst), .i_vsync(vs), .i_hsync(hs), .i_de(de),
    .o_vsync(p_vsync), .o_hsync(p_hsync), .o_de(p_de), .o_x(p_x), .o_y(p_y),
    .o_frame_start(p_fs), .o_line_start(p_ls), .o_locked(p_lock),
    .o_scl_en(p_en), .o_err(p_err)
  );

  scaler_timing_ctrl #(.VSYNC_POL(1'b1), .HSYNC_POL(1'b1)) dut_n (
    .clk(clk), .rst(rst), .i_vsync(vs_n), .i_hsync(hs_n), .i_de(de),
    .o_vsync(n_vsync), .o_hsync(n_hsync), .o_de(n_de), .o_x(n_x), .o_y(n_y),
    .o_frame_start(n_fs), .o_line_start(n_ls), .o_locked(n_lock),
    .o_scl_en(n_en), .o_err(n_err)
  );

  function automatic frame_vec_t mk(input int vfp, input int bad, input int rl,
                                    input logic [2:0] err, input logic lock);
    frame_vec_t f;
    f.vfp = vfp; f.bad_hact = bad; f.rst_line = rl; f.err = err; f.lock = lock;
    return f;
  endfunction

  task automatic check_cycle(input string tag, input exp_t e,
                             input logic a_vs, input logic a_hs, input logic a_de,
                             input logic a_fs, input logic a_ls,
                             input logic [XW-1:0] a_x, input logic [YW-1:0] a_y,
                             input logic a_lk, input logic a_en, input logic [2:0] a_err);
    logic ok;
    n_checks++;
    ok = (a_vs == e.vs) && (a_hs == e.hs) && (a_de == e.de) && (a_fs == e.fs) &&
         (a_ls == e.ls) && (a_lk == e.lock) && (a_en == e.lock) && (a_err == e.err);
    if (e.de && ((a_x != e.x) || (a_y != e.y))) ok = 1'b0;
    if (!ok) begin
      n_errors++;
      $display("FAIL %s t=%0t got vs%b hs%b de%b fs%b ls%b x%0d y%0d lk%b en%b err%b want vs%b hs%b de%b fs%b ls%b x%0d y%0d lk%b en%b err%b",
               tag, $time, a_vs, a_hs, a_de, a_fs, a_ls, a_x, a_y, a_lk, a_en, a_err,
               e.vs, e.hs, e.de, e.fs, e.ls, e.x, e.y, e.lock, e.lock, e.err);
    end
  endtask

  task automatic check_zero(input string tag);
    logic [63:0] agg;
    agg = {p_vsync, p_hsync, p_de, p_fs, p_ls, p_lock, p_en, p_err, p_x, p_y,
           n_vsync, n_hsync, n_de, n_fs, n_ls, n_lock, n_en, n_err};
    n_checks++;
    if (agg != '0 || n_x != '0 || n_y != '0) begin
      n_errors++;
      $display("FAIL %s t=%0t outputs got %h / nx%0d ny%0d, want all zero", tag, $time, agg, n_x, n_y);
    end
  endtask

  // One stimulus cycle: compare the cycle driven two negedges ago, then drive
  task automatic step(input exp_t e);
    @(negedge clk);
    if (pipe1.vld) begin
      check_cycle("cyc_pos", pipe1, p_vsync, p_hsync, p_de, p_fs, p_ls, p_x, p_y, p_lock, p_en, p_err);
      check_cycle("cyc_neg", pipe1, n_vsync, n_hsync, n_de, n_fs, n_ls, n_x, n_y, n_lock, n_en, n_err);
    end
    pipe1 = pipe0;
    pipe0 = e;
    pipe0.vld = e.vld & chk_en;
    vs = e.vs; hs = e.hs; de = e.de;
  endtask

  task automatic drive_frame(input frame_vec_t f);
    int nlines;
    nlines = T_VSW + T_VBP + T_VACT + f.vfp;
    for (int l = 0; l < nlines; l++) begin
      for (int c = 0; c < T_HTOT; c++) begin
        exp_t e;
        int   hact;
        if (l == 0 && c == 0) chk_en = 1'b1;
        hact   = (f.bad_hact != 0 && l == T_VSW + T_VBP + 1) ? f.bad_hact : T_HACT;
        e.de   = (l >= T_VSW + T_VBP) && (l < T_VSW + T_VBP + T_VACT) &&
                 (c >= T_HSW + T_HBP) && (c < T_HSW + T_HBP + hact);
        e.vs   = (l < T_VSW);
        e.hs   = (c < T_HSW);
        e.fs   = (l == 0) && (c == 0);
        e.ls   = e.de && (c == T_HSW + T_HBP);
        e.x    = XW'(c - (T_HSW + T_HBP));
        e.y    = YW'(l - (T_VSW + T_VBP));
        e.lock = f.lock;
        e.err  = f.err;
        e.vld  = 1'b1;
        step(e);
        if (rst) rst = 1'b0;
        if (l == f.rst_line && c == 5) begin
          #3 rst = 1'b1;
          #1 check_zero("rst_mid");
          chk_en    = 1'b0;
          pipe0.vld = 1'b0;
          pipe1.vld = 1'b0;
        end
      end
    end
  endtask

  initial begin
    exp_t idle;
    idle.vs = 0; idle.hs = 0; idle.de = 0; idle.fs = 0; idle.ls = 0;
    idle.x = '0; idle.y = '0; idle.lock = 0; idle.err = 3'b000; idle.vld = 1;
    pipe0 = idle; pipe0.vld = 0;
    pipe1 = idle; pipe1.vld = 0;

    // err/lock hold for the whole frame, taking effect at its frame start
    fv[0]  = mk(1, 0, -1, 3'b000, 1'b0);
    fv[1]  = mk(1, 0, -1, 3'b000, 1'b0);
    fv[2]  = mk(1, 0, -1, 3'b000, 1'b1);
    fv[3]  = mk(1, 9, -1, 3'b000, 1'b1);
    fv[4]  = mk(1, 9, -1, 3'b001, 1'b1);
    fv[5]  = mk(2, 0, -1, 3'b001, 1'b0);
    fv[6]  = mk(2, 0, -1, 3'b100, 1'b0);
    fv[7]  = mk(2, 0, -1, 3'b100, 1'b0);
    fv[8]  = mk(2, 0, -1, 3'b100, 1'b0);
    fv[9]  = mk(1, 0, -1, 3'b100, 1'b0);
    fv[10] = mk(1, 0, -1, 3'b000, 1'b0);
    fv[11] = mk(1, 0, -1, 3'b000, 1'b1);
    fv[12] = mk(1, 0,  3, 3'b000, 1'b1);
    fv[13] = mk(1, 0, -1, 3'b000, 1'b0);
    fv[14] = mk(1, 0, -1, 3'b000, 1'b0);
    fv[15] = mk(1, 0, -1, 3'b000, 1'b1);

    // Reset state
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;
    repeat (10) step(idle);

    for (int i = 0; i < 16; i++) drive_frame(fv[i]);

    // Long idle after reset: nothing may move
    @(negedge clk);
    rst = 1'b1; vs = 0; hs = 0; de = 0;
    pipe0.vld = 1'b0; pipe1.vld = 1'b0;
    @(negedge clk);
    rst = 1'b0; chk_en = 1'b1;
    repeat (1000) step(idle);
    n_checks++;
    if (dut_p.state != ST_UNLOCK || dut_n.state != ST_UNLOCK) begin
      n_errors++;
      $display("FAIL idle_state got %0d/%0d want %0d", dut_p.state, dut_n.state, ST_UNLOCK);
    end
    check_zero("idle_end");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
